// File: rtl/vga_timing_gen.sv
// vga_timing_gen: generic VGA sync/blank/colour timing with pixel enable.
// Ports: clk_in, reset (async, low), pix_en, pixel_color {R,G,B} in;
// h_sync, v_sync, red/green/blue_out, blank_out, sync_n_out, clk_out to DAC;
// next_x, next_y, next_active, line_start, frame_start to the renderer.
module vga_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int H_SYNC_POL = 0,
  parameter int V_SYNC_POL = 0,
  parameter int COLOR_W    = 8,
  parameter int PIPE_LAT   = 1,
  parameter int COORD_W    = 11
) (
  input  logic                   clk_in,
  input  logic                   reset,
  input  logic                   pix_en,
  input  logic [3*COLOR_W-1:0]   pixel_color,
  output logic                   h_sync,
  output logic                   v_sync,
  output logic [COLOR_W-1:0]     red_out,
  output logic [COLOR_W-1:0]     green_out,
  output logic [COLOR_W-1:0]     blue_out,
  output logic                   sync_n_out,
  output logic                   clk_out,
  output logic                   blank_out,
  output logic [COORD_W-1:0]     next_x,
  output logic [COORD_W-1:0]     next_y,
  output logic                   next_active,
  output logic                   line_start,
  output logic                   frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int VW = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FRONT);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FRONT + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FRONT);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FRONT + V_SYNC - 1);
  localparam logic H_ON = 1'(H_SYNC_POL);
  localparam logic V_ON = 1'(V_SYNC_POL);

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic          h_act, v_act, hs_raw, vs_raw;
  // {hs, vs, active}; all-zero means deasserted and blanked
  logic [2:0]    raw, tail;

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (pix_en) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + VW'(1);
      end else begin
        h_cnt_d = h_cnt_q + HW'(1);
      end
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign h_act  = h_cnt_q < H_ACT;
  assign v_act  = v_cnt_q < V_ACT;
  assign hs_raw = (h_cnt_q >= HS_BEG) && (h_cnt_q <= HS_END);
  assign vs_raw = (v_cnt_q >= VS_BEG) && (v_cnt_q <= VS_END);

  assign next_active = h_act & v_act;
  assign next_x      = h_act ? COORD_W'(h_cnt_q) : '0;
  assign next_y      = v_act ? COORD_W'(v_cnt_q) : '0;
  assign line_start  = pix_en & (h_cnt_q == '0);
  assign frame_start = line_start & (v_cnt_q == '0);

  assign raw = {hs_raw, vs_raw, next_active};

  // Delays the decode by the renderer's fetch latency so the tail
  // lines up with the pixel_color currently presented.
  generate
    if (PIPE_LAT == 0) begin : g_nodly
      assign tail = raw;
    end else begin : g_dly
      logic [2:0] dl_q [PIPE_LAT];
      always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
          for (int i = 0; i < PIPE_LAT; i++) dl_q[i] <= '0;
        end else if (pix_en) begin
          dl_q[0] <= raw;
          for (int i = 1; i < PIPE_LAT; i++) dl_q[i] <= dl_q[i-1];
        end
      end
      assign tail = dl_q[PIPE_LAT-1];
    end
  endgenerate

  logic               hs_q, vs_q, blank_q;
  logic [COLOR_W-1:0] r_q, g_q, b_q;

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      hs_q    <= ~H_ON;
      vs_q    <= ~V_ON;
      blank_q <= 1'b0;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
    end else if (pix_en) begin
      hs_q    <= tail[2] ? H_ON : ~H_ON;
      vs_q    <= tail[1] ? V_ON : ~V_ON;
      blank_q <= tail[0];
      r_q     <= tail[0] ? pixel_color[3*COLOR_W-1 -: COLOR_W] : '0;
      g_q     <= tail[0] ? pixel_color[2*COLOR_W-1 -: COLOR_W] : '0;
      b_q     <= tail[0] ? pixel_color[COLOR_W-1:0] : '0;
    end
  end

  assign h_sync     = hs_q;
  assign v_sync     = vs_q;
  assign blank_out  = blank_q;
  assign red_out    = r_q;
  assign green_out  = g_q;
  assign blue_out   = b_q;
  assign sync_n_out = 1'b0;
  assign clk_out    = clk_in;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: three configurations against an index-based model.
// Random pix_en, garbage colour outside active video, async mid-run reset.
module tb_vga_timing_gen;

  typedef struct {
    int ha, hf, hs, hb;
    int va, vf, vs, vb;
    int hpol, vpol, lat;
  } cfg_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pix_en = 1'b0;
  logic [23:0] pc [3];
  logic        hs [3], vs [3], bl [3], sn [3], co [3];
  logic        na [3], ls [3], fs [3];
  logic [7:0]  r [3], g [3], b [3];
  logic [10:0] nx [3], ny [3];

  cfg_t cfg [3];
  int   n;
  int   n_chk, n_err;
  bit   meas, cnt_on;
  int   hs_run, bl_run, hs_exp, bl_exp;
  int   ls_cnt [3], fs_cnt [3], coin_bad;

  always #5 clk = ~clk;

  vga_timing_gen u_a (
    .clk_in(clk), .reset(reset), .pix_en(pix_en), .pixel_color(pc[0]),
    .h_sync(hs[0]), .v_sync(vs[0]), .red_out(r[0]), .green_out(g[0]),
    .blue_out(b[0]), .sync_n_out(sn[0]), .clk_out(co[0]),
    .blank_out(bl[0]), .next_x(nx[0]), .next_y(ny[0]),
    .next_active(na[0]), .line_start(ls[0]), .frame_start(fs[0])
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .H_SYNC_POL(1), .PIPE_LAT(0)
  ) u_b (
    .clk_in(clk), .reset(reset), .pix_en(pix_en), .pixel_color(pc[1]),
    .h_sync(hs[1]), .v_sync(vs[1]), .red_out(r[1]), .green_out(g[1]),
    .blue_out(b[1]), .sync_n_out(sn[1]), .clk_out(co[1]),
    .blank_out(bl[1]), .next_x(nx[1]), .next_y(ny[1]),
    .next_active(na[1]), .line_start(ls[1]), .frame_start(fs[1])
  );

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
    .V_ACTIVE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .V_SYNC_POL(1), .PIPE_LAT(3)
  ) u_c (
    .clk_in(clk), .reset(reset), .pix_en(pix_en), .pixel_color(pc[2]),
    .h_sync(hs[2]), .v_sync(vs[2]), .red_out(r[2]), .green_out(g[2]),
    .blue_out(b[2]), .sync_n_out(sn[2]), .clk_out(co[2]),
    .blank_out(bl[2]), .next_x(nx[2]), .next_y(ny[2]),
    .next_active(na[2]), .line_start(ls[2]), .frame_start(fs[2])
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void pos(input cfg_t c, input int idx,
                              output int h, output int v);
    int ht, vt, f;
    ht = c.ha + c.hf + c.hs + c.hb;
    vt = c.va + c.vf + c.vs + c.vb;
    f  = idx % (ht * vt);
    h  = f % ht;
    v  = f / ht;
  endfunction

  function automatic logic [23:0] colorf(input int x, input int y);
    return {8'(x), 8'(y), 8'h5A};
  endfunction

  // Pins seen after the register holding the decode of counter index idx.
  function automatic logic [28:0] exp_pins(input cfg_t c, input int idx);
    int h, v;
    bit act, hsa, vsa;
    logic [23:0] col;
    act = 0; hsa = 0; vsa = 0; h = 0; v = 0;
    if (idx >= 0) begin
      pos(c, idx, h, v);
      act = (h < c.ha) && (v < c.va);
      hsa = (h >= c.ha + c.hf) && (h < c.ha + c.hf + c.hs);
      vsa = (v >= c.va + c.vf) && (v < c.va + c.vf + c.vs);
    end
    col = act ? colorf(h, v) : 24'h0;
    return {hsa ? 1'(c.hpol) : ~1'(c.hpol),
            vsa ? 1'(c.vpol) : ~1'(c.vpol),
            act, col, 1'b0, 1'b0};
  endfunction

  function automatic logic [24:0] exp_comb(input cfg_t c, input int idx,
                                           input bit en);
    int h, v;
    pos(c, idx, h, v);
    return {(h < c.ha) ? 11'(h) : 11'd0,
            (v < c.va) ? 11'(v) : 11'd0,
            (h < c.ha) && (v < c.va),
            en && (h == 0),
            en && (h == 0) && (v == 0)};
  endfunction

  function automatic logic [23:0] drive_col(input cfg_t c, input int cnt);
    int idx, h, v;
    idx = cnt - c.lat;
    if (idx >= 0) begin
      pos(c, idx, h, v);
      if ((h < c.ha) && (v < c.va)) return colorf(h, v);
    end
    return 24'($urandom);
  endfunction

  task automatic step(input bit en, input bit rst_v);
    @(negedge clk);
    reset  = rst_v;
    pix_en = en;
    if (!rst_v) n = 0;
    for (int d = 0; d < 3; d++) pc[d] = drive_col(cfg[d], n);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("pins%0d", d),
          64'({hs[d], vs[d], bl[d], r[d], g[d], b[d], sn[d], co[d]}),
          64'(exp_pins(cfg[d], n - 1 - cfg[d].lat)));
      chk($sformatf("coord%0d", d),
          64'({nx[d], ny[d], na[d], ls[d], fs[d]}),
          64'(exp_comb(cfg[d], n, en)));
      if (cnt_on) begin
        ls_cnt[d] += ls[d] ? 1 : 0;
        fs_cnt[d] += fs[d] ? 1 : 0;
        if (fs[d] && !ls[d]) coin_bad++;
      end
    end
    if (meas) begin
      if (!hs[0]) hs_run++;
      else if (hs_run > 0) begin
        chk("hs_low_run", 64'(hs_run), 64'(hs_exp));
        hs_run = 0;
      end
      if (bl[0]) bl_run++;
      else if (bl_run > 0) begin
        chk("blank_run", 64'(bl_run), 64'(bl_exp));
        bl_run = 0;
      end
    end
    if (rst_v && en) n++;
  endtask

  initial begin
    logic [28:0] t;
    int k;
    n = 0; n_chk = 0; n_err = 0;
    meas = 0; cnt_on = 0; coin_bad = 0;
    hs_run = 0; bl_run = 0; hs_exp = 0; bl_exp = 0;
    for (int d = 0; d < 3; d++) begin
      ls_cnt[d] = 0;
      fs_cnt[d] = 0;
      pc[d] = '0;
    end
    cfg[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 1};
    cfg[1] = '{4, 1, 2, 1, 3, 1, 1, 1, 1, 0, 0};
    cfg[2] = '{16, 2, 4, 3, 6, 1, 2, 1, 0, 1, 3};

    #2 reset = 1'b0;
    #1;
    for (int d = 0; d < 3; d++)
      chk($sformatf("rst_pins%0d", d),
          64'({hs[d], vs[d], bl[d], r[d], g[d], b[d], sn[d], co[d]}),
          64'(exp_pins(cfg[d], -1)));
    step(0, 0);
    step(0, 0);

    hs_exp = 96; bl_exp = 640; hs_run = 0; bl_run = 0; meas = 1;
    repeat (2000) step(1, 1);
    meas = 0;

    step(0, 0);
    step(0, 0);
    hs_exp = 192; bl_exp = 1280; hs_run = 0; bl_run = 0; meas = 1;
    for (int i = 0; i < 3300; i++) step(i % 2 == 0, 1);
    meas = 0;

    repeat (15000) step($urandom_range(0, 3) != 0, 1);

    k = 0;
    t = exp_pins(cfg[0], n - 1 - cfg[0].lat);
    while (t[26] == 1'b0 && k < 2000) begin
      step(1, 1);
      k++;
      t = exp_pins(cfg[0], n - 1 - cfg[0].lat);
    end
    chk("pre_rst_blank", 64'(bl[0]), 64'(1));

    step(0, 0);
    step(0, 0);

    cnt_on = 1;
    repeat (500) step(1, 1);
    cnt_on = 0;
    chk("ls_cnt_a", 64'(ls_cnt[0]), 64'(1));
    chk("fs_cnt_a", 64'(fs_cnt[0]), 64'(1));
    chk("ls_cnt_b", 64'(ls_cnt[1]), 64'(63));
    chk("fs_cnt_b", 64'(fs_cnt[1]), 64'(11));
    chk("ls_cnt_c", 64'(ls_cnt[2]), 64'(20));
    chk("fs_cnt_c", 64'(fs_cnt[2]), 64'(2));
    chk("fs_wo_ls", 64'(coin_bad), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
